// File: rtl/gf_pkg.sv
// Shared constants and types for the GF(2^M) multiply-accumulate block.
package gf_pkg;

    localparam int unsigned GF_M_DEFAULT = 5;

    // Low M bits of x^5 + x^2 + 1 (x^M term implied).
    localparam logic [GF_M_DEFAULT-1:0] GF_POLY_DEFAULT = 5'b00101;

    localparam logic GF_MODE_MAC    = 1'b0;
    localparam logic GF_MODE_HORNER = 1'b1;

    // Frame state: IDLE/ACC live in the state register; HOLD is carried
    // by the out_valid register, since it is orthogonal to frame progress.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } gf_state_e;

endpackage

// File: rtl/gf_mult.sv
// Combinational polynomial-basis multiplier over GF(2^M), reduced by POLY.
module gf_mult
    import gf_pkg::*;
#(
    parameter int unsigned     M    = GF_M_DEFAULT,
    parameter logic [M-1:0]    POLY = M'(GF_POLY_DEFAULT)
) (
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic [M-1:0] p
);

    logic [M-1:0] sh;
    logic [M-1:0] bb;

    // Shift-and-add: sh walks a*x^i (reduced each step), added where b has a 1.
    always_comb begin
        p  = '0;
        sh = a;
        bb = b;
        for (int unsigned i = 0; i < M; i++) begin
            if (bb[0]) begin
                p = p ^ sh;
            end
            sh = {sh[M-2:0], 1'b0} ^ (sh[M-1] ? POLY : '0);
            bb = bb >> 1;
        end
    end

endmodule

// File: rtl/gf_mac.sv
// Streaming GF(2^M) dot-product / Horner evaluator with a one-deep result register.
module gf_mac
    import gf_pkg::*;
#(
    parameter int unsigned     M    = GF_M_DEFAULT,
    parameter logic [M-1:0]    POLY = M'(GF_POLY_DEFAULT),
    parameter int unsigned     CW   = 6
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          mode,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [M-1:0]  in_a,
    input  logic [M-1:0]  in_b,
    input  logic          in_first,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [M-1:0]  out_data,
    output logic [CW-1:0] out_count
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    gf_state_e     state, state_n;
    logic [M-1:0]  acc, acc_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          mode_q, mode_n;
    logic          out_valid_n;
    logic [M-1:0]  out_data_n;
    logic [CW-1:0] out_count_n;
    logic          accept;
    logic          eff_mode;
    logic [M-1:0]  prod_ab;
    logic [M-1:0]  prod_acc;

    // Result register can take a new value whenever it is empty or draining.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    // Mode pin only matters on a first beat; otherwise the latched mode rules.
    assign eff_mode = in_first ? mode : mode_q;

    gf_mult #(.M(M), .POLY(POLY)) u_mul_ab (
        .a (in_a),
        .b (in_b),
        .p (prod_ab)
    );

    gf_mult #(.M(M), .POLY(POLY)) u_mul_acc (
        .a (acc),
        .b (in_b),
        .p (prod_acc)
    );

    // State, accumulator, counter and result registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            acc       <= '0;
            cnt       <= '0;
            mode_q    <= GF_MODE_MAC;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            cnt       <= cnt_n;
            mode_q    <= mode_n;
            out_valid <= out_valid_n;
            out_data  <= out_data_n;
            out_count <= out_count_n;
        end
    end

    // Next-state: accumulate accepted beats, publish on last, drain on out_ready.
    always_comb begin
        state_n     = state;
        acc_n       = acc;
        cnt_n       = cnt;
        mode_n      = mode_q;
        out_valid_n = out_valid;
        out_data_n  = out_data;
        out_count_n = out_count;

        if (out_ready) begin
            out_valid_n = 1'b0;
        end

        if (accept) begin
            mode_n = eff_mode;
            if (eff_mode == GF_MODE_HORNER) begin
                acc_n = in_first ? in_a : (prod_acc ^ in_a);
            end else begin
                acc_n = in_first ? prod_ab : (acc ^ prod_ab);
            end

            if (in_first) begin
                cnt_n = CW'(1);
            end else if (cnt != CNT_MAX) begin
                cnt_n = cnt + CW'(1);
            end

            if (in_last) begin
                out_valid_n = 1'b1;
                out_data_n  = acc_n;
                out_count_n = cnt_n;
                state_n     = ST_IDLE;
            end else begin
                state_n     = ST_ACC;
            end
        end
    end

endmodule

// File: tb/tb_gf_mac.sv
// Self-checking bench for gf_mac: directed table, corner sequences, random frames.
module tb_gf_mac;

    localparam int M         = 5;
    localparam int POLY_FULL = 'h25;   // x^5 + x^2 + 1
    localparam int CNT_MAX   = 63;     // CW = 6
    localparam int CNT_MAX_S = 3;      // CW = 2

    typedef struct {
        logic md;
        int   a;
        int   b;
        logic f;
        logic l;
        int   exp_data;   // -1: no result expected after this beat
        int   exp_cnt;
    } vec_t;

    typedef struct {
        int data;
        int cnt;
    } res_t;

    logic         clock;
    logic         reset;
    logic         mode;
    logic         in_valid;
    logic [M-1:0] in_a;
    logic [M-1:0] in_b;
    logic         in_first;
    logic         in_last;
    logic         out_ready;
    logic         in_ready, in_ready_s;
    logic         out_valid, out_valid_s;
    logic [M-1:0] out_data, out_data_s;
    logic [5:0]   out_count;
    logic [1:0]   out_count_s;

    int   checks;
    int   errors;
    logic rand_ready;
    vec_t vecs[$];
    res_t exp_q[$];
    int   m_acc, m_cnt, m_md;
    logic m_mode;
    logic lat_pend;

    gf_mac #(.M(5), .POLY(5'b00101), .CW(6)) dut (
        .clock     (clock),
        .reset     (reset),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    gf_mac #(.M(5), .POLY(5'b00101), .CW(2)) dut_s (
        .clock     (clock),
        .reset     (reset),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready_s),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid_s),
        .out_ready (out_ready),
        .out_data  (out_data_s),
        .out_count (out_count_s)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Carry-less product followed by long division by the full polynomial.
    function automatic int gf_ref(input int a, input int b);
        int p = 0;
        for (int i = 0; i < M; i++) begin
            if (((b >> i) & 1) != 0) p = p ^ (a << i);
        end
        for (int k = 2 * M - 2; k >= M; k--) begin
            if (((p >> k) & 1) != 0) p = p ^ (POLY_FULL << (k - M));
        end
        return p;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic add_vec(input logic md, input int a, input int b, input logic f,
                           input logic l, input int ed, input int ec);
        vec_t v;
        v.md = md; v.a = a; v.b = b; v.f = f; v.l = l; v.exp_data = ed; v.exp_cnt = ec;
        vecs.push_back(v);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    endtask

    // Present one beat and hold it until accepted; returns at edge + 1.
    task automatic send_beat(input logic md, input int a, input int b,
                             input logic f, input logic l);
        logic acc_seen;
        acc_seen = 1'b0;
        mode = md; in_a = 5'(a); in_b = 5'(b); in_first = f; in_last = l;
        in_valid = 1'b1;
        for (int n = 0; n < 50 && !acc_seen; n++) begin
            @(negedge clock);
            acc_seen = in_ready;
            @(posedge clock);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        if (!acc_seen) chk("accept_timeout", 0, 1);
    endtask

    // Scoreboard: model accepted beats, check every presented result.
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            m_acc = 0; m_cnt = 0; m_mode = 1'b0; lat_pend = 1'b0;
        end else begin
            if (lat_pend) begin
                chk("latency_valid", int'(out_valid), 1);
                lat_pend = 1'b0;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("stale_output", 1, 0);
                end else begin
                    chk("sb_data", int'(out_data), exp_q[0].data);
                    chk("sb_count", int'(out_count), sat(exp_q[0].cnt, CNT_MAX));
                    chk("sb_data_s", int'(out_data_s), exp_q[0].data);
                    chk("sb_count_s", int'(out_count_s), sat(exp_q[0].cnt, CNT_MAX_S));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            chk("in_ready", int'(in_ready), int'(!out_valid || out_ready));
            if (in_valid && in_ready) begin
                m_md = in_first ? int'(mode) : int'(m_mode);
                if (m_md == 0)
                    m_acc = (in_first ? 0 : m_acc) ^ gf_ref(int'(in_a), int'(in_b));
                else
                    m_acc = in_first ? int'(in_a) : (gf_ref(m_acc, int'(in_b)) ^ int'(in_a));
                m_mode = 1'(m_md);
                m_cnt  = in_first ? 1 : m_cnt + 1;
                if (in_last) begin
                    exp_q.push_back('{data: m_acc, cnt: m_cnt});
                    lat_pend = 1'b1;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; rand_ready = 1'b0;
        reset = 1'b1; mode = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;

        add_vec(0,  2, 16, 1, 0, -1, 0);
        add_vec(0,  3,  1, 0, 1,  6, 2);
        add_vec(1,  3,  0, 1, 0, -1, 0);
        add_vec(0,  1,  2, 0, 1,  7, 2);   // mode pin ignored mid-frame
        add_vec(0, 31,  1, 1, 1, 31, 1);
        add_vec(1,  9,  7, 1, 1,  9, 1);
        add_vec(0,  7,  7, 1, 0, -1, 0);
        add_vec(0,  1,  1, 1, 0, -1, 0);   // restart discards 7*7
        add_vec(1,  2,  2, 0, 1,  5, 2);
        add_vec(1,  1,  0, 1, 0, -1, 0);
        add_vec(0,  0,  3, 0, 0, -1, 0);
        add_vec(0,  2,  3, 0, 1,  7, 3);
        add_vec(0,  1,  1, 1, 0, -1, 0);
        add_vec(1,  2,  2, 0, 0, -1, 0);
        add_vec(0,  3,  3, 0, 0, -1, 0);
        add_vec(1,  4,  4, 0, 0, -1, 0);
        add_vec(0,  5,  5, 0, 1,  1, 5);   // count saturates to 3 on CW=2

        // Reset values.
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_count", int'(out_count), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        reset = 1'b0;
        idle(1);

        // Non-first beat before any first: MAC onto zero, mode pin ignored.
        send_beat(1, 3, 7, 0, 1);
        chk("nofirst_data", int'(out_data), 9);
        chk("nofirst_count", int'(out_count), 1);

        for (int i = 0; i < vecs.size(); i++) begin
            send_beat(vecs[i].md, vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].l);
            if (vecs[i].exp_data >= 0) begin
                chk($sformatf("vec%0d_valid", i), int'(out_valid), 1);
                chk($sformatf("vec%0d_data", i), int'(out_data), vecs[i].exp_data);
                chk($sformatf("vec%0d_count", i), int'(out_count), vecs[i].exp_cnt);
                chk($sformatf("vec%0d_count_s", i), int'(out_count_s),
                    sat(vecs[i].exp_cnt, CNT_MAX_S));
            end else begin
                chk($sformatf("vec%0d_novalid", i), int'(out_valid), 0);
            end
        end

        // Back-pressure: result held for 3 cycles, pending beat taken with no bubble.
        idle(2);
        out_ready = 1'b0;
        send_beat(0, 31, 1, 1, 1);
        chk("stall_valid", int'(out_valid), 1);
        mode = 1'b1; in_a = 5'd9; in_b = 5'd3; in_first = 1'b1; in_last = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("stall_in_ready", int'(in_ready), 0);
            chk("stall_hold_data", int'(out_data), 31);
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clock);
        chk("release_in_ready", int'(in_ready), 1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        chk("nobubble_valid", int'(out_valid), 1);
        chk("nobubble_data", int'(out_data), 9);
        chk("nobubble_count", int'(out_count), 1);

        // Reset mid-frame discards the partial result.
        idle(2);
        send_beat(0, 5, 5, 1, 0);
        send_beat(0, 6, 6, 0, 0);
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_count", int'(out_count), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle(1);
        chk("postrst_valid", int'(out_valid), 0);
        send_beat(0, 2, 16, 1, 1);
        chk("postrst_data", int'(out_data), 5);
        chk("postrst_count", int'(out_count), 1);
        idle(2);

        // Random frames with random back-pressure and mode pin noise.
        rand_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int j = 0; j < len; j++) begin
                send_beat(1'($urandom_range(0, 1)), $urandom_range(0, 31),
                          $urandom_range(0, 31), j == 0, j == len - 1);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;
        idle(4);
        chk("drain_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gf_mac.md
GF_MAC -- requirements
Module: gf_mac

Interface
REQ-001 SHALL have parameter M, default 5, meaning symbol width in bits (GF(2^M)), legal range 3..8.
REQ-002 SHALL have parameter POLY, default 5'b00101, meaning the low M bits of the primitive polynomial (x^M implied); the default is x^5+x^2+1.
REQ-003 SHALL have parameter CW, default 6, meaning the beat-counter width.
REQ-004 SHALL have ports, in order:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- mode  in  1  0 = dot-product (MAC), 1 = Horner evaluation; sampled only on a first beat.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when high with in_valid.
- in_a  in  M  coefficient/operand A.
- in_b  in  M  operand B, or the evaluation point in Horner mode.
- in_first  in  1  beat starts a new frame.
- in_last  in  1  beat ends the frame.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  M  frame result.
- out_count  out  CW  beats in the frame.

Function
REQ-005 A beat SHALL be accepted when in_valid and in_ready are both high on a rising clock edge.
REQ-006 MAC mode SHALL update acc_next = acc XOR gfmul(in_a,in_b); a first beat SHALL instead load acc = gfmul(in_a,in_b).
REQ-007 Horner mode SHALL update acc_next = gfmul(acc,in_b) XOR in_a; a first beat SHALL instead load acc = in_a.
REQ-008 gfmul SHALL be a polynomial-basis product reduced modulo POLY and SHALL be purely combinational.
REQ-009 Addition SHALL be bitwise XOR with no carries; all datapaths SHALL be M bits wide.
REQ-010 When a last beat is accepted, out_data SHALL present the updated accumulator value with out_valid high in the next cycle (latency 1).
REQ-011 out_data and out_count SHALL hold stable while out_valid && !out_ready.
REQ-012 in_ready SHALL equal !out_valid || out_ready, i.e. back-pressure applies only when the result register is full and not being drained.
REQ-013 When a result is drained and a new last beat is accepted on the same edge, out_valid SHALL stay high with the new result; no bubble is allowed.
REQ-014 A beat with both first and last SHALL produce a single-term result: gfmul(a,b) in MAC mode, in_a in Horner mode.
REQ-015 A first beat arriving mid-frame SHALL discard the partial accumulation and restart.
REQ-016 A non-first beat arriving before any first beat since reset SHALL accumulate onto acc = 0 in the current latched mode (reset value 0 = MAC).
REQ-017 The beat counter SHALL load 1 on a first beat, increment on other beats, and saturate at 2^CW-1; out_count SHALL be its value including the last beat.
REQ-018 The latched mode SHALL remain unchanged for the rest of the frame regardless of the mode pin.
REQ-019 The state machine SHALL have three states:
- IDLE: no frame open. → ACC on an accepted non-last beat.
- ACC: frame open. → IDLE on an accepted last beat.
- HOLD: out_valid high, orthogonal to the other two states.

Reset
REQ-020 While reset is high, the following SHALL be held low/zero asynchronously: out_valid, out_data, out_count, acc, counter, latched mode, and the state (IDLE).
REQ-021 in_ready SHALL be 1 during reset per REQ-012, but no beat SHALL be accepted while reset is high.
REQ-022 Reset mid-frame SHALL discard the frame; no partial result is emitted.

Structure
REQ-023 Package gf_pkg SHALL hold the default M, the default POLY, the mode encodings (GF_MODE_MAC = 0, GF_MODE_HORNER = 1), and the state enum.
REQ-024 The multiplier SHALL be a separate sub-module gf_mult #(M,POLY), instanced twice: once for A·B and once for acc·B; muxing selects the path by mode.

Verification
REQ-025 With M=5 and default POLY, MAC frame (a=2,b=16 first),(a=3,b=1 last) SHALL give out_data=6 and out_count=2, one cycle after the last beat.
REQ-026 Horner frame (a=3 first),(a=1,b=2 last) SHALL give out_data=7 and out_count=2.
REQ-027 A single beat first+last, MAC, a=31, b=1 SHALL give out_data=31 and out_count=1.
REQ-028 With out_ready held low for 3 cycles after a result: in_ready SHALL stay 0, out_data SHALL stay stable, and a pending beat SHALL be accepted on the edge where out_ready=1 with no bubble.
REQ-029 Asserting reset mid-frame (after 2 beats), then sending a first+last beat a=2, b=16 SHALL give out_data=5, out_count=1, and no stale output.
REQ-030 With CW=2, a 5-beat frame SHALL give out_count=3 (saturated) and a correct out_data.
